// File: rtl/outdisp_pkg.sv
// Shared types and seven-segment constants for the output display unit.
// Segment patterns are active-low, ordered gfedcba.
package outdisp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        UPDATE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/output_display_unit_bcd_to_seg7.sv
// One BCD digit to its active-low seven-segment pattern.
// Codes 10-15 come out blank.
module bcd_to_seg7
    import outdisp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = digit_pattern(bcd);

endmodule

// File: rtl/output_display_unit.sv
// Captures the value of an `out` instruction and shows it in decimal on seven-segment digits.
// OUTDISP_BLANK_LEADING_EN: blank leading zeros and draw a minus left of the leading digit.
//
// state  | meaning
// IDLE   | waiting for a strobe or a pending value
// LOAD   | take sign and magnitude of the captured value, clear BCD
// SHIFT  | one double-dabble step per cycle, DATA_W cycles
// UPDATE | register display outputs from the BCD result
module output_display_unit
    import outdisp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 8,
    parameter int BCD_DIGITS = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    singOut,
    input  logic [DATA_W-1:0]       data_in,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    neg,
    output logic                    overflow,
    output logic                    busy,
    output logic                    dropped
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int BCD_W = 4 * BCD_DIGITS;

    state_t                  state_q, state_d;
    logic [DATA_W-1:0]       cur_q, cur_d;
    logic [DATA_W-1:0]       pend_q, pend_d;
    logic                    pend_full_q, pend_full_d;
    logic                    dropped_q, dropped_d;
    logic                    sign_q, sign_d;
    logic [DATA_W-1:0]       mag_q, mag_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic                    neg_q, neg_d;
    logic                    ovf_q, ovf_d;

    logic [BCD_W-1:0]        bcd_adj;
    logic [7*NUM_DIGITS-1:0] seg_new;
    logic                    ovf_new;
    logic [6:0]              dig_seg [NUM_DIGITS];

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        bcd_to_seg7 u_dig (
            .bcd (bcd_q[4*k +: 4]),
            .seg (dig_seg[k])
        );
    end

    assign ovf_new = |bcd_q[BCD_W-1:4*NUM_DIGITS];

`ifdef OUTDISP_BLANK_LEADING_EN
    logic                  any_nz;
    logic [NUM_DIGITS-1:0] shown;

    // Overflow shows every digit; otherwise a digit is shown if it or anything above it is nonzero.
    always_comb begin
        any_nz  = ovf_new;
        shown   = '0;
        seg_new = {NUM_DIGITS{SEG_BLANK}};
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            any_nz   = any_nz | (bcd_q[4*k +: 4] != 4'd0) | (k == 0);
            shown[k] = any_nz;
        end
        seg_new[6:0] = dig_seg[0];
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (shown[k])
                seg_new[7*k +: 7] = dig_seg[k];
            else if (sign_q && shown[k-1])
                seg_new[7*k +: 7] = SEG_MINUS;
            else
                seg_new[7*k +: 7] = SEG_BLANK;
        end
    end
`else
    always_comb begin
        seg_new = '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            seg_new[7*k +: 7] = dig_seg[k];
    end
`endif

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        dropped_d   = 1'b0;
        sign_d      = sign_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        seg_d       = seg_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;

        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++)
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;

        case (state_q)
            IDLE: begin
                // A waiting value goes first; a coincident strobe refills the buffer.
                if (pend_full_q) begin
                    cur_d       = pend_q;
                    pend_full_d = singOut;
                    if (singOut)
                        pend_d = data_in;
                    state_d = LOAD;
                end else if (singOut) begin
                    cur_d   = data_in;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                sign_d  = cur_q[DATA_W-1];
                mag_d   = cur_q[DATA_W-1] ? -cur_q : cur_q;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    cnt_d   = '0;
                    state_d = UPDATE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UPDATE: begin
                seg_d   = seg_new;
                neg_d   = sign_q;
                ovf_d   = ovf_new;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (singOut && state_q != IDLE) begin
            pend_d      = data_in;
            pend_full_d = 1'b1;
            dropped_d   = pend_full_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            dropped_q   <= 1'b0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            seg_q       <= {NUM_DIGITS{SEG_BLANK}};
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            dropped_q   <= dropped_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            seg_q       <= seg_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
        end
    end

    // A waiting value counts as busy so the flag does not dip between back-to-back conversions.
    assign busy     = (state_q != IDLE) || pend_full_q;
    assign seg      = seg_q;
    assign neg      = neg_q;
    assign overflow = ovf_q;
    assign dropped  = dropped_q;

endmodule
